// File: rtl/en_count_pkg.sv
// en_count_pkg: shared constants for the enable-pulse generator
// Provides the default counter/period width used by the snake-game top level.
package en_count_pkg;
  localparam int EN_COUNT_WIDTH = 24;
endpackage

// File: rtl/en_count.sv
// en_count: programmable clock-enable divider, one-cycle en strobe every max cycles (max 0 acts as 1)
// Ports: CLK1_50 system clock; RESET sync active-high; max period in cycles; en registered strobe.
module en_count
  import en_count_pkg::*;
#(
  parameter int WIDTH = EN_COUNT_WIDTH
) (
  input  logic             CLK1_50,
  input  logic             RESET,
  input  logic [WIDTH-1:0] max,
  output logic             en
);
  logic [WIDTH-1:0] r_cnt;
  logic [WIDTH-1:0] w_last;
  logic             w_wrap;
  // Terminal count P-1 in WIDTH bits; >= lets a shrunk max wrap on the very next edge.
  always_comb begin
    w_last = (max == '0) ? '0 : max - 1'b1;
    w_wrap = r_cnt >= w_last;
  end
  always_ff @(posedge CLK1_50) begin
    if (RESET) begin
      r_cnt <= '0;
      en    <= 1'b0;
    end else begin
      r_cnt <= w_wrap ? '0 : r_cnt + 1'b1;
      en    <= w_wrap;
    end
  end
`ifndef SYNTHESIS
  a_no_en_after_reset: assert property (@(posedge CLK1_50) RESET |=> !en);
  // After a counting edge the count never exceeds the terminal value in force at that edge.
  a_cnt_bounded: assert property (@(posedge CLK1_50) !RESET |=> r_cnt <= $past(w_last));
  a_single_pulse: assert property (@(posedge CLK1_50) (en && w_last != '0) |=> !en);
`endif
endmodule

// File: tb/tb_en_count.sv
// tb_en_count: scenario bench for en_count with a queue of expected en values per edge
module tb_en_count;
  localparam int W = 4;
  logic         CLK1_50 = 1'b0;
  logic         RESET = 1'b1;
  logic [W-1:0] max = '0;
  logic         en;
  logic         sb[$];
  int           checks = 0;
  int           errors = 0;

  en_count #(.WIDTH(W)) dut (
    .CLK1_50(CLK1_50),
    .RESET(RESET),
    .max(max),
    .en(en)
  );

  always #10 CLK1_50 = ~CLK1_50;

  // Apply inputs for one edge, queue the en expected after it, then step past the edge.
  task automatic drive(input logic r, input logic [W-1:0] m, input logic e);
    RESET = r;
    max = m;
    sb.push_back(e);
    @(posedge CLK1_50);
    #1;
  endtask

  task automatic test_reset();
    logic exp_en;
    for (int i = 0; i < 15; i++) begin
      drive(i < 3, 4'd4, i >= 3 && (i - 2) % 4 == 0);
      exp_en = sb.pop_front();
      checks++;
      if (en !== exp_en) begin
        errors++;
        $display("FAIL reset step %0d: en=%b expected %b", i, en, exp_en);
      end
    end
  endtask

  task automatic test_degenerate();
    logic exp_en;
    logic [W-1:0] m;
    for (int i = 0; i < 13; i++) begin
      m = (i < 5) ? 4'd0 : (i < 9) ? 4'd1 : 4'd2;
      drive(i == 0, m, (i >= 1 && i < 9) || (i >= 9 && (i - 9) % 2 == 1));
      exp_en = sb.pop_front();
      checks++;
      if (en !== exp_en) begin
        errors++;
        $display("FAIL degenerate step %0d max=%0d: en=%b expected %b", i, m, en, exp_en);
      end
    end
  endtask

  task automatic test_shrink();
    logic exp_en;
    for (int i = 0; i < 15; i++) begin
      drive(i == 0, (i < 8) ? 4'd10 : 4'd3, i >= 8 && (i - 8) % 3 == 0);
      exp_en = sb.pop_front();
      checks++;
      if (en !== exp_en) begin
        errors++;
        $display("FAIL shrink step %0d: en=%b expected %b", i, en, exp_en);
      end
    end
  endtask

  task automatic test_grow();
    logic exp_en;
    for (int i = 0; i < 17; i++) begin
      drive(i == 0, (i < 3) ? 4'd4 : 4'd8, i == 8 || i == 16);
      exp_en = sb.pop_front();
      checks++;
      if (en !== exp_en) begin
        errors++;
        $display("FAIL grow step %0d: en=%b expected %b", i, en, exp_en);
      end
    end
  endtask

  task automatic test_collision();
    logic exp_en;
    for (int i = 0; i < 13; i++) begin
      drive(i == 0 || i == 4, 4'd4, i == 8 || i == 12);
      exp_en = sb.pop_front();
      checks++;
      if (en !== exp_en) begin
        errors++;
        $display("FAIL collision step %0d: en=%b expected %b", i, en, exp_en);
      end
    end
  endtask

  task automatic test_large();
    logic exp_en;
    for (int i = 0; i < 31; i++) begin
      drive(i == 0, 4'd15, i == 15 || i == 30);
      exp_en = sb.pop_front();
      checks++;
      if (en !== exp_en) begin
        errors++;
        $display("FAIL large step %0d: en=%b expected %b", i, en, exp_en);
      end
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_degenerate();
    test_shrink();
    test_grow();
    test_collision();
    test_large();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard drain: %0d left, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
